// File: rtl/jk_bank_pkg.sv
// -----------------------------------------------------------------------------
// jk_bank_pkg
// Shared definitions for the JK flip-flop bank arbiter:
//   - command op encoding (hold / reset / set / toggle)
//   - arbiter FSM state encoding
//   - J/K pair type and the op -> J/K translation
//   - index range check used to flag commands aimed past the bank
// -----------------------------------------------------------------------------
package jk_bank_pkg;

    // Command op encoding carried on reqK_op.
    localparam logic [1:0] OP_HOLD   = 2'b00;
    localparam logic [1:0] OP_RESET  = 2'b01;
    localparam logic [1:0] OP_SET    = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    // Index width is fixed; the range check below relies on it.
    localparam int IDX_W_FIXED = 3;

    // Arbiter FSM states: a command always walks IDLE -> APPLY -> DONE -> IDLE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_APPLY = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    // J/K drive pair for a single flip-flop.
    typedef struct packed {
        logic j;
        logic k;
    } jk_t;

    // Translate a command op into the J/K pair that performs it.
    function automatic jk_t op_to_jk(input logic [1:0] op);
        jk_t jk;
        case (op)
            OP_HOLD:   begin jk.j = 1'b0; jk.k = 1'b0; end
            OP_RESET:  begin jk.j = 1'b0; jk.k = 1'b1; end
            OP_SET:    begin jk.j = 1'b1; jk.k = 1'b0; end
            OP_TOGGLE: begin jk.j = 1'b1; jk.k = 1'b1; end
            default:   begin jk.j = 1'b0; jk.k = 1'b0; end
        endcase
        return jk;
    endfunction

    // True when idx names a flip-flop that does not exist in an n-wide bank.
    function automatic logic idx_out_of_range(input logic [IDX_W_FIXED-1:0] idx,
                                              input int                     n);
        return (int'({{(32-IDX_W_FIXED){1'b0}}, idx}) >= n);
    endfunction

endpackage

// File: rtl/jkflipflop.sv
// -----------------------------------------------------------------------------
// jkflipflop
// Single JK flip-flop cell with asynchronous active-high reset.
//   clk : clock, Q updates on the rising edge
//   rst : asynchronous reset, forces Q to 0
//   J,K : 00 hold, 01 clear, 10 set, 11 toggle
//   Q   : flip-flop output
// -----------------------------------------------------------------------------
module jkflipflop (
    input  logic clk,
    input  logic rst,
    input  logic J,
    input  logic K,
    output logic Q
);

    logic q_d;
    logic q_q;

    // Next-state function of the JK cell.
    always_comb begin
        q_d = q_q;
        case ({J, K})
            2'b00:   q_d = q_q;
            2'b01:   q_d = 1'b0;
            2'b10:   q_d = 1'b1;
            2'b11:   q_d = ~q_q;
            default: q_d = q_q;
        endcase
    end

    // State register with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q = q_q;

endmodule

// File: rtl/jk_bank_arbiter.sv
// -----------------------------------------------------------------------------
// jk_bank_arbiter
// Two-requester round-robin arbiter in front of a bank of N JK flip-flops.
// A granted command is captured, applied to one flip-flop, then reported
// with a one-cycle done pulse. One command completes every three cycles.
//
// Ports:
//   clk                    : clock, rising edge
//   rst                    : asynchronous active-high reset
//   req{0,1}_valid         : requester presents a command
//   req{0,1}_op   [1:0]    : 00 hold, 01 reset, 10 set, 11 toggle
//   req{0,1}_idx  [IDX_W]  : target flip-flop index
//   req{0,1}_ready         : arbiter accepts this requester this cycle
//   done                   : one-cycle completion pulse
//   done_id                : requester number of the completed command
//   err                    : completed command targeted idx >= N
//   busy                   : FSM is not IDLE
//   q             [N]      : bank outputs, bit i from flip-flop i
// -----------------------------------------------------------------------------
module jk_bank_arbiter
    import jk_bank_pkg::*;
#(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [1:0]       req0_op,
    input  logic [IDX_W-1:0] req0_idx,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [1:0]       req1_op,
    input  logic [IDX_W-1:0] req1_idx,
    output logic             req1_ready,
    output logic             done,
    output logic             done_id,
    output logic             err,
    output logic             busy,
    output logic [N-1:0]     q
);

    state_e           state_d, state_q;
    logic [1:0]       cap_op_d, cap_op_q;
    logic [IDX_W-1:0] cap_idx_d, cap_idx_q;
    logic             cap_id_d, cap_id_q;
    logic             cap_err_d, cap_err_q;
    logic             last_grant_d, last_grant_q;

    logic             ready0_s;
    logic             ready1_s;
    logic [N-1:0]     j_s;
    logic [N-1:0]     k_s;
    logic [N-1:0]     q_bank_s;
    jk_t              jk_s;

    // Arbitration, command capture and FSM next state.
    always_comb begin
        state_d      = state_q;
        cap_op_d     = cap_op_q;
        cap_idx_d    = cap_idx_q;
        cap_id_d     = cap_id_q;
        cap_err_d    = cap_err_q;
        last_grant_d = last_grant_q;
        ready0_s     = 1'b0;
        ready1_s     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Ready is masked while rst is high so nothing is offered
                // during reset. Under contention the requester that was not
                // granted last wins; last_grant resets to 1 so req0 wins first.
                if (!rst) begin
                    ready0_s = req0_valid && (!req1_valid || last_grant_q);
                    ready1_s = req1_valid && (!req0_valid || !last_grant_q);
                end else begin
                    ready0_s = 1'b0;
                    ready1_s = 1'b0;
                end

                if (ready0_s) begin
                    cap_op_d     = req0_op;
                    cap_idx_d    = req0_idx;
                    cap_id_d     = 1'b0;
                    cap_err_d    = idx_out_of_range(req0_idx, N);
                    last_grant_d = 1'b0;
                    state_d      = ST_APPLY;
                end else if (ready1_s) begin
                    cap_op_d     = req1_op;
                    cap_idx_d    = req1_idx;
                    cap_id_d     = 1'b1;
                    cap_err_d    = idx_out_of_range(req1_idx, N);
                    last_grant_d = 1'b1;
                    state_d      = ST_APPLY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_APPLY: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state and captured command registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cap_op_q     <= OP_HOLD;
            cap_idx_q    <= {IDX_W{1'b0}};
            cap_id_q     <= 1'b0;
            cap_err_q    <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cap_op_q     <= cap_op_d;
            cap_idx_q    <= cap_idx_d;
            cap_id_q     <= cap_id_d;
            cap_err_q    <= cap_err_d;
            last_grant_q <= last_grant_d;
        end
    end

    // J/K decode: only the captured target sees a non-zero pair, and only
    // during APPLY, so it updates on the edge that ends APPLY. Out-of-range
    // commands drive nothing.
    always_comb begin
        j_s  = {N{1'b0}};
        k_s  = {N{1'b0}};
        jk_s = op_to_jk(cap_op_q);
        if ((state_q == ST_APPLY) && !cap_err_q) begin
            for (int i = 0; i < N; i++) begin
                if (cap_idx_q == IDX_W'(i)) begin
                    j_s[i] = jk_s.j;
                    k_s[i] = jk_s.k;
                end else begin
                    j_s[i] = 1'b0;
                    k_s[i] = 1'b0;
                end
            end
        end else begin
            j_s = {N{1'b0}};
            k_s = {N{1'b0}};
        end
    end

    // The bank itself: one JK cell per bit.
    for (genvar gi = 0; gi < N; gi++) begin : g_bank
        jkflipflop u_ff (
            .clk (clk),
            .rst (rst),
            .J   (j_s[gi]),
            .K   (k_s[gi]),
            .Q   (q_bank_s[gi])
        );
    end

    // Status outputs are decoded straight from registered state, so they
    // clear asynchronously with rst and an aborted command never pulses done.
    assign req0_ready = ready0_s;
    assign req1_ready = ready1_s;
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign done_id    = (state_q == ST_DONE) && cap_id_q;
    assign err        = (state_q == ST_DONE) && cap_err_q;
    assign q          = q_bank_s;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// -----------------------------------------------------------------------------
// tb_jk_bank_arbiter
// Directed bench for jk_bank_arbiter: an N=8 instance covers reset, the op
// sweep, contention, mid-command reset and back-to-back throughput; an N=6
// instance covers the out-of-range error path.
// -----------------------------------------------------------------------------
module tb_jk_bank_arbiter;
    import jk_bank_pkg::*;

    logic clk = 1'b0;
    logic rst;

    // N=8 instance signals
    logic       v0, v1;
    logic [1:0] op0, op1;
    logic [2:0] idx0, idx1;
    logic       rdy0, rdy1, done8, did8, err8, busy8;
    logic [7:0] q8;

    // N=6 instance signals
    logic       w0v, w1v;
    logic [1:0] w0op, w1op;
    logic [2:0] w0idx, w1idx;
    logic       wrdy0, wrdy1, done6, did6, err6, busy6;
    logic [5:0] q6;

    int n_checks = 0;
    int n_fail   = 0;

    int hs_cyc [4];
    int n_hs;
    int tries;

    logic [1:0] sweep_op [5];
    logic [7:0] sweep_q  [5];

    always #5 clk = ~clk;

    jk_bank_arbiter #(.N(8), .IDX_W(3)) dut8 (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_op(op0), .req0_idx(idx0), .req0_ready(rdy0),
        .req1_valid(v1), .req1_op(op1), .req1_idx(idx1), .req1_ready(rdy1),
        .done(done8), .done_id(did8), .err(err8), .busy(busy8), .q(q8)
    );

    jk_bank_arbiter #(.N(6), .IDX_W(3)) dut6 (
        .clk(clk), .rst(rst),
        .req0_valid(w0v), .req0_op(w0op), .req0_idx(w0idx), .req0_ready(wrdy0),
        .req1_valid(w1v), .req1_op(w1op), .req1_idx(w1idx), .req1_ready(wrdy1),
        .done(done6), .done_id(did6), .err(err6), .busy(busy6), .q(q6)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset pulse of one edge; ends at posedge+1 with rst low.
    task automatic rst_pulse();
        rst = 1'b1;
        #1;
        chk("rst_q", 32'(q8), 32'h0);
        chk("rst_busy", 32'(busy8), 32'h0);
        step();
        rst = 1'b0;
    endtask

    // Issue a req0 command and stop at posedge+1 inside its DONE cycle.
    task automatic run_cmd0(input logic [1:0] op, input logic [2:0] idx);
        op0   = op;
        idx0  = idx;
        v0    = 1'b1;
        #1;
        tries = 0;
        while (!rdy0 && tries < 8) begin
            step();
            tries++;
        end
        chk("hs_timeout", 32'(tries < 8), 32'h1);
        step();
        v0 = 1'b0;
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        sweep_op[0] = OP_SET;    sweep_q[0] = 8'h20;
        sweep_op[1] = OP_RESET;  sweep_q[1] = 8'h00;
        sweep_op[2] = OP_TOGGLE; sweep_q[2] = 8'h20;
        sweep_op[3] = OP_HOLD;   sweep_q[3] = 8'h20;
        sweep_op[4] = OP_TOGGLE; sweep_q[4] = 8'h00;
        for (int i = 0; i < 4; i++) hs_cyc[i] = 0;

        rst = 1'b1;
        v0 = 1'b1; op0 = OP_SET; idx0 = 3'd3;
        v1 = 1'b0; op1 = OP_HOLD; idx1 = 3'd0;
        w0v = 1'b0; w0op = OP_HOLD; w0idx = 3'd0;
        w1v = 1'b0; w1op = OP_HOLD; w1idx = 3'd0;

        // Reset state, with a valid request pending that must not be offered
        repeat (2) @(posedge clk);
        #1;
        chk("reset_q", 32'(q8), 32'h0);
        chk("reset_busy", 32'(busy8), 32'h0);
        chk("reset_done", 32'(done8), 32'h0);
        chk("reset_err", 32'(err8), 32'h0);
        chk("reset_rdy0", 32'(rdy0), 32'h0);
        chk("reset_rdy1", 32'(rdy1), 32'h0);

        // Single set idx=3; first edge after reset accepts it
        rst = 1'b0;
        #1;
        chk("single_rdy0", 32'(rdy0), 32'h1);
        step();
        chk("apply_busy", 32'(busy8), 32'h1);
        chk("apply_rdy0", 32'(rdy0), 32'h0);
        chk("apply_q", 32'(q8), 32'h0);
        v0 = 1'b0; op0 = OP_TOGGLE; idx0 = 3'd0;   // must not disturb the command in flight
        step();
        chk("single_q", 32'(q8), 32'h08);
        chk("single_done", 32'(done8), 32'h1);
        chk("single_did", 32'(did8), 32'h0);
        chk("single_err", 32'(err8), 32'h0);
        step();
        chk("single_done_low", 32'(done8), 32'h0);
        chk("single_idle", 32'(busy8), 32'h0);

        // Op sweep on idx=5 from a clean bank
        rst_pulse();
        for (int i = 0; i < 5; i++) begin
            run_cmd0(sweep_op[i], 3'd5);
            chk("sweep_q", 32'(q8), 32'(sweep_q[i]));
            chk("sweep_done", 32'(done8), 32'h1);
            step();
        end

        // Contention: both held valid, round-robin starting with req0
        rst_pulse();
        v0 = 1'b1; op0 = OP_SET; idx0 = 3'd0;
        v1 = 1'b1; op1 = OP_SET; idx1 = 3'd1;
        #1;
        chk("cont1_rdy0", 32'(rdy0), 32'h1);
        chk("cont1_rdy1", 32'(rdy1), 32'h0);
        step();
        chk("cont1_wait_rdy1", 32'(rdy1), 32'h0);
        step();
        chk("cont1_q", 32'(q8), 32'h01);
        chk("cont1_did", 32'(did8), 32'h0);
        step();
        chk("cont2_rdy0", 32'(rdy0), 32'h0);
        chk("cont2_rdy1", 32'(rdy1), 32'h1);
        step();
        step();
        chk("cont2_q", 32'(q8), 32'h03);
        chk("cont2_did", 32'(did8), 32'h1);
        chk("cont2_done", 32'(done8), 32'h1);
        step();
        chk("cont3_rdy0", 32'(rdy0), 32'h1);
        chk("cont3_rdy1", 32'(rdy1), 32'h0);
        step();
        step();
        chk("cont3_did", 32'(did8), 32'h0);
        step();
        chk("cont4_rdy1", 32'(rdy1), 32'h1);
        chk("cont4_rdy0", 32'(rdy0), 32'h0);
        v0 = 1'b0; v1 = 1'b0;
        #1;
        chk("withdrawn_rdy1", 32'(rdy1), 32'h0);
        step();
        chk("withdrawn_busy", 32'(busy8), 32'h0);
        chk("cont_final_q", 32'(q8), 32'h03);

        // Reset during APPLY of set idx=2
        v0 = 1'b1; op0 = OP_SET; idx0 = 3'd2;
        #1;
        step();
        chk("midrst_busy_before", 32'(busy8), 32'h1);
        rst = 1'b1;
        v0  = 1'b0;
        #1;
        chk("midrst_q", 32'(q8), 32'h0);
        chk("midrst_busy", 32'(busy8), 32'h0);
        chk("midrst_done", 32'(done8), 32'h0);
        step();
        rst = 1'b0;
        step();
        chk("midrst_no_done1", 32'(done8), 32'h0);
        step();
        chk("midrst_no_done2", 32'(done8), 32'h0);
        run_cmd0(OP_SET, 3'd2);
        chk("after_rst_q", 32'(q8), 32'h04);
        chk("after_rst_done", 32'(done8), 32'h1);
        step();

        // Back-to-back toggles on idx 0..3 with req0 held valid
        n_hs = 0;
        op0  = OP_TOGGLE; idx0 = 3'd0; v0 = 1'b1;
        for (int c = 0; c < 20; c++) begin
            #1;
            chk("b2b_ready_idle_only", 32'(rdy0 && busy8), 32'h0);
            if (rdy0 && v0 && n_hs < 4) begin
                hs_cyc[n_hs] = c;
                n_hs++;
                step();
                if (n_hs == 4) v0 = 1'b0;
                else           idx0 = 3'(n_hs);
            end else begin
                step();
            end
        end
        chk("b2b_count", 32'(n_hs), 32'd4);
        for (int i = 0; i < 3; i++) begin
            chk("b2b_gap", 32'(hs_cyc[i+1] - hs_cyc[i]), 32'd3);
        end
        chk("b2b_q", 32'(q8), 32'h0B);

        // Error path on the N=6 bank
        w1v = 1'b1; w1op = OP_SET; w1idx = 3'd2;
        #1;
        chk("err_pre_rdy1", 32'(wrdy1), 32'h1);
        step();
        w1v = 1'b0;
        step();
        chk("err_pre_q", 32'(q6), 32'h04);
        chk("err_pre_err", 32'(err6), 32'h0);
        step();
        w1v = 1'b1; w1op = OP_TOGGLE; w1idx = 3'd7;
        #1;
        step();
        w1v = 1'b0;
        step();
        chk("err_done", 32'(done6), 32'h1);
        chk("err_err", 32'(err6), 32'h1);
        chk("err_did", 32'(did6), 32'h1);
        chk("err_q", 32'(q6), 32'h04);
        step();
        chk("err_done_low", 32'(done6), 32'h0);
        chk("err_err_low", 32'(err6), 32'h0);
        chk("err_q_after", 32'(q6), 32'h04);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
